// File: rtl/ram_copy_engine.sv
// ram_copy_engine: word-by-word memory-to-memory copy master for a single-port RAM.
// Define RAM_COPY_CHECKSUM_EN to add a checksum output (sum of every word written).
module ram_copy_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] words_copied,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_is_write,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_COPY_CHECKSUM_EN
   ,output logic [DATA_W-1:0] checksum
`endif
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] src_ptr, dst_ptr, remaining;
    logic [DATA_W-1:0] data_q;
    // Outputs are pure decodes of registered state, so reset clears them asynchronously
    assign busy         = (state == READ) || (state == WRITE);
    assign done         = state == DONE;
    assign ram_is_write = state == WRITE;
    assign ram_address  = state == READ ? src_ptr : state == WRITE ? dst_ptr : '0;
    assign ram_wdata    = data_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            src_ptr      <= '0;
            dst_ptr      <= '0;
            remaining    <= '0;
            data_q       <= '0;
            words_copied <= '0;
`ifdef RAM_COPY_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    src_ptr      <= src_addr;
                    dst_ptr      <= dst_addr;
                    remaining    <= length;
                    words_copied <= '0;
`ifdef RAM_COPY_CHECKSUM_EN
                    checksum     <= '0;
`endif
                    state        <= length != '0 ? READ : DONE;
                end
                READ: begin
                    data_q <= ram_rdata;
                    state  <= WRITE;
                end
                WRITE: begin
                    src_ptr      <= src_ptr + ADDR_W'(1);
                    dst_ptr      <= dst_ptr + ADDR_W'(1);
                    remaining    <= remaining - ADDR_W'(1);
                    words_copied <= words_copied + ADDR_W'(1);
`ifdef RAM_COPY_CHECKSUM_EN
                    checksum     <= checksum + data_q;
`endif
                    state        <= remaining == ADDR_W'(1) ? DONE : READ;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_copy_engine.sv
// tb_ram_copy_engine: randomized and directed copies checked against an array-based reference memory.
module tb_ram_copy_engine;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src_addr = '0, dst_addr = '0, length = '0;
    logic        busy, done, ram_is_write;
    logic [15:0] words_copied, ram_address;
    logic [31:0] ram_wdata, ram_rdata;
`ifdef RAM_COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif
    logic        tb_we = 1'b0;
    logic [15:0] tb_a = '0;
    logic [31:0] tb_d = '0;
    logic [31:0] mem [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic [31:0] exp_sum;
    int          n_checks = 0, n_fail = 0;

    ram_copy_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .length(length), .busy(busy), .done(done), .words_copied(words_copied),
        .ram_address(ram_address), .ram_is_write(ram_is_write), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
`ifdef RAM_COPY_CHECKSUM_EN
       ,.checksum(checksum)
`endif
    );

    always #5 clk = ~clk;
    assign ram_rdata = mem[ram_address];
    always @(posedge clk)
        if (ram_is_write) mem[ram_address] <= ram_wdata;
        else if (tb_we) mem[tb_a] <= tb_d;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_a = a; tb_d = v;
        @(posedge clk); #1;
        tb_we = 1'b0;
        ref_mem[a] = v;
    endtask

    // Reference: forward word-by-word copy of the first n words, modulo-2^16 addresses
    task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
        logic [31:0] w;
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            w = ref_mem[s + 16'(i)];
            ref_mem[d + 16'(i)] = w;
            exp_sum += w;
        end
    endtask

    task automatic check_dst(input logic [15:0] d, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = d + 16'(i);
            check("dst_word", mem[a], ref_mem[a]);
        end
    endtask

    task automatic do_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l, input bit hold);
        int k, busy_n, wr_n;
        @(negedge clk);
        src_addr = s; dst_addr = d; length = l; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        check("wc_cleared", words_copied, 0);
        k = 0; busy_n = 0; wr_n = 0;
        while (!done && k <= 2 * int'(l) + 4) begin
            if (busy) busy_n++;
            if (ram_is_write) wr_n++;
            @(posedge clk); #1;
            k++;
        end
        check("done_latency", k, 2 * int'(l));
        check("busy_cycles", busy_n, 2 * int'(l));
        check("write_cycles", wr_n, l);
        check("words_copied", words_copied, l);
        check("busy_in_done", busy, 0);
        model_copy(s, d, int'(l));
`ifdef RAM_COPY_CHECKSUM_EN
        check("checksum", checksum, exp_sum);
`endif
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("wc_hold", words_copied, l);
        check_dst(d, int'(l));
    endtask

    initial begin
        logic [15:0] s, d, l;
        bit          saw_done;
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wc", words_copied, 0);
        check("rst_addr", ram_address, 0);
        check("rst_we", ram_is_write, 0);
        check("rst_wdata", ram_wdata, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        preload(16'h0010, 32'hE5F84AB1);
        preload(16'h0011, 32'h5C8C6A01);
        preload(16'h0012, 32'h00000007);
        do_copy(16'h0010, 16'h0100, 16'd3, 1'b0);
`ifdef RAM_COPY_CHECKSUM_EN
        check("checksum_const", checksum, 32'h4284B4B9);
`endif
        check("idle_addr", ram_address, 0);

        do_copy(16'h0020, 16'h0030, 16'd0, 1'b0);

        for (int i = 0; i < 4; i++) preload(16'hFFFE + 16'(i), 32'(i + 1));
        do_copy(16'hFFFE, 16'h2000, 16'd4, 1'b0);
        for (int i = 0; i < 4; i++) check("wrap_word", mem[16'h2000 + 16'(i)], 32'(i + 1));

        preload(16'h0040, 32'hA5A5A5A5);
        do_copy(16'h0040, 16'h0041, 16'd3, 1'b0);
        for (int i = 1; i <= 3; i++) check("overlap_word", mem[16'h0040 + 16'(i)], 32'hA5A5A5A5);

        for (int i = 0; i < 2; i++) preload(16'h0300 + 16'(i), $urandom);
        for (int i = 0; i < 2; i++) preload(16'h0310 + 16'(i), $urandom);
        do_copy(16'h0300, 16'h0400, 16'd2, 1'b1);
        do_copy(16'h0310, 16'h0410, 16'd2, 1'b0);

        for (int t = 0; t < 8; t++) begin
            s = 16'($urandom);
            d = 16'($urandom);
            l = 16'($urandom_range(1, 12));
            for (int i = 0; i < int'(l); i++) preload(s + 16'(i), $urandom);
            do_copy(s, d, l, 1'b0);
        end

        // Reset during the 4th WRITE of an 8-word copy, with a stray start mid-copy
        for (int i = 0; i < 8; i++) preload(16'h0500 + 16'(i), $urandom);
        for (int i = 0; i < 8; i++) preload(16'h0600 + 16'(i), 32'hDEAD0000 + 32'(i));
        @(negedge clk);
        src_addr = 16'h0500; dst_addr = 16'h0600; length = 16'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        saw_done = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
            if (k == 1) begin
                start = 1'b1;
                src_addr = 16'h0700; dst_addr = 16'h0800; length = 16'd1;
            end
            if (k == 2) start = 1'b0;
        end
        check("pre_rst_we", ram_is_write, 1);
        check("pre_rst_wc", words_copied, 3);
        reset_n = 1'b0;
        #1;
        check("mid_rst_we", ram_is_write, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_wc", words_copied, 0);
        check("mid_rst_addr", ram_address, 0);
        check("mid_rst_wdata", ram_wdata, 0);
`ifdef RAM_COPY_CHECKSUM_EN
        check("mid_rst_checksum", checksum, 0);
`endif
        @(posedge clk); #1;
        if (done) saw_done = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("no_done_on_rst", saw_done, 0);
        check("idle_after_rst", busy, 0);
        model_copy(16'h0500, 16'h0600, 3);
        check_dst(16'h0600, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
